// File: rtl/disparity_window_feeder_if.sv
// Bundle between the disparity window feeder and its row memories / calc unit.
// master = feeder side, slave = memory + correlation calc side.
interface disparity_window_feeder_if;
   logic        go;
   logic [7:0]  base_place;
   logic [7:0]  f_addr;
   logic [2:0]  f_rd;
   logic [7:0]  g_addr;
   logic [2:0]  g_rd;
   logic [7:0]  startplace;
   logic        startsig;
   logic        work;
   logic        valid;
   logic [2:0]  fdata;
   logic [2:0]  gdata;
   logic        change;
   logic        finalstart;
   logic [10:0] fsum;
   logic [13:0] f2sum;
   logic        busy;
   logic        done;

   modport master (
      input  go, base_place, f_rd, g_rd,
      output f_addr, g_addr, startplace, startsig, work, valid, fdata, gdata,
             change, finalstart, fsum, f2sum, busy, done
   );

   modport slave (
      output go, base_place, f_rd, g_rd,
      input  f_addr, g_addr, startplace, startsig, work, valid, fdata, gdata,
             change, finalstart, fsum, f2sum, busy, done
   );
endinterface

// File: rtl/disparity_window_feeder.sv
// Sequencer feeding reference/candidate pixel pairs to the stereo correlation calc unit.
//
// state  | meaning
// IDLE   | waiting for go; base latched and sums cleared on accept
// PRE    | WIN+1 cycles: read reference window, accumulate fsum/f2sum
// START  | 1 cycle: startsig, startplace = B + d
// STREAM | WIN+1 cycles: issue addresses 0..WIN-1, pixels valid on 1..WIN
// CHANGE | 1 cycle: change pulse, finalstart on the last candidate
// DONE   | 1 cycle: done pulse, back to IDLE
module disparity_window_feeder #(
   parameter int WIN   = 8,
   parameter int NCAND = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   disparity_window_feeder_if.master  bus
);

   localparam int            IW    = $clog2(WIN + 1);
   localparam logic [IW-1:0] I_END = IW'(WIN);
   localparam logic [7:0]    D_END = 8'(NCAND - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_START,
      S_STREAM,
      S_CHANGE,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    b;
   logic [7:0]    d;
   logic [IW-1:0] i;
   logic [7:0]    i8;
   logic [7:0]    startplace_q;
   logic [10:0]   fsum_q;
   logic [13:0]   f2sum_q;
   logic [2:0]    fdata_q;
   logic [2:0]    gdata_q;
   logic [5:0]    f_sq;
   logic          last_i;
   logic          last_d;
   logic          valid_c;
   logic          startsig_c;
   logic          work_c;
   logic          change_c;
   logic          busy_c;
   logic          done_c;

   assign i8     = 8'(i);
   assign last_i = (i == I_END);
   assign last_d = (d == D_END);
   assign f_sq   = 6'(bus.f_rd) * 6'(bus.f_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      valid_c    = 1'b0;
      startsig_c = 1'b0;
      work_c     = 1'b0;
      change_c   = 1'b0;
      busy_c     = 1'b1;
      done_c     = 1'b0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.go) state_nxt = S_PRE;
         end
         S_PRE: begin
            if (last_i) state_nxt = S_START;
         end
         S_START: begin
            startsig_c = 1'b1;
            work_c     = 1'b1;
            state_nxt  = S_STREAM;
         end
         S_STREAM: begin
            work_c  = 1'b1;
            valid_c = (i != '0);
            if (last_i) state_nxt = S_CHANGE;
         end
         S_CHANGE: begin
            work_c    = 1'b1;
            change_c  = 1'b1;
            state_nxt = last_d ? S_DONE : S_START;
         end
         S_DONE: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b            <= '0;
         d            <= '0;
         i            <= '0;
         startplace_q <= '0;
         fsum_q       <= '0;
         f2sum_q      <= '0;
         fdata_q      <= '0;
         gdata_q      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.go) begin
                  b       <= bus.base_place;
                  d       <= '0;
                  i       <= '0;
                  fsum_q  <= '0;
                  f2sum_q <= '0;
               end
            end
            S_PRE: begin
               // read data lags the address by one cycle, so index 0 has nothing to add yet
               if (i != '0) begin
                  fsum_q  <= fsum_q + 11'(bus.f_rd);
                  f2sum_q <= f2sum_q + 14'(f_sq);
               end
               if (last_i) begin
                  i            <= '0;
                  startplace_q <= b;
               end else begin
                  i <= i + IW'(1);
               end
            end
            S_START: i <= '0;
            S_STREAM: begin
               if (valid_c) begin
                  fdata_q <= bus.f_rd;
                  gdata_q <= bus.g_rd;
               end
               i <= last_i ? '0 : i + IW'(1);
            end
            S_CHANGE: begin
               if (!last_d) begin
                  d            <= d + 8'd1;
                  startplace_q <= b + d + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.f_addr     = b + i8;
   assign bus.g_addr     = b + d + i8;
   assign bus.startplace = startplace_q;
   assign bus.startsig   = startsig_c;
   assign bus.work       = work_c;
   assign bus.valid      = valid_c;
   // pass live memory data on valid cycles so pairs line up with valid; hold otherwise
   assign bus.fdata      = valid_c ? bus.f_rd : fdata_q;
   assign bus.gdata      = valid_c ? bus.g_rd : gdata_q;
   assign bus.change     = change_c;
   assign bus.finalstart = change_c & last_d;
   assign bus.fsum       = fsum_q;
   assign bus.f2sum      = f2sum_q;
   assign bus.busy       = busy_c;
   assign bus.done       = done_c;

endmodule

// File: tb/tb_disparity_window_feeder.sv
// Scoreboard bench: unit A (WIN=8, NCAND=4) and unit B (WIN=1, NCAND=1) with row memory models.
module tb_disparity_window_feeder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   disparity_window_feeder_if ia ();
   disparity_window_feeder_if ib ();

   disparity_window_feeder #(.WIN(8), .NCAND(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   disparity_window_feeder #(.WIN(1), .NCAND(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   logic [2:0] fmem_a [256];
   logic [2:0] gmem_a [256];
   logic [2:0] fmem_b [256];
   logic [2:0] gmem_b [256];

   always @(posedge clk) begin
      ia.f_rd <= fmem_a[ia.f_addr];
      ia.g_rd <= gmem_a[ia.g_addr];
      ib.f_rd <= fmem_b[ib.f_addr];
      ib.g_rd <= gmem_b[ib.g_addr];
   end

   // scoreboard queues and tracked hold values
   logic [5:0] qa_pix[$];
   logic [7:0] qa_sp[$];
   logic       qa_fin[$];
   int         qa_done[$];
   logic [5:0] qb_pix[$];
   logic [7:0] qb_sp[$];
   logic       qb_fin[$];
   int         qb_done[$];
   logic [10:0] exp_fs_a, exp_fs_b;
   logic [13:0] exp_f2_a, exp_f2_b;
   logic [5:0]  last_pix_a = '0, last_pix_b = '0;
   logic [7:0]  last_sp_a = '0, last_sp_b = '0;
   int          done_cnt_a = 0, done_cnt_b = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endfunction

   function automatic logic [63:0] outs_a();
      return 64'({ia.f_addr, ia.g_addr, ia.startplace, ia.startsig, ia.work, ia.valid,
                  ia.fdata, ia.gdata, ia.change, ia.finalstart, ia.fsum, ia.f2sum,
                  ia.busy, ia.done});
   endfunction

   function automatic logic [63:0] outs_b();
      return 64'({ib.f_addr, ib.g_addr, ib.startplace, ib.startsig, ib.work, ib.valid,
                  ib.fdata, ib.gdata, ib.change, ib.finalstart, ib.fsum, ib.f2sum,
                  ib.busy, ib.done});
   endfunction

   // monitor for unit A
   always @(negedge clk) if (rst_n) begin
      logic [5:0] e;
      if (ia.valid) begin
         chk("a_valid_expected", 64'(qa_pix.size() != 0), 1);
         if (qa_pix.size() != 0) begin
            e = qa_pix.pop_front();
            chk("a_fdata", 64'(ia.fdata), 64'(e[5:3]));
            chk("a_gdata", 64'(ia.gdata), 64'(e[2:0]));
            last_pix_a = e;
         end
      end else begin
         chk("a_pix_hold", 64'({ia.fdata, ia.gdata}), 64'(last_pix_a));
      end
      if (ia.startsig) begin
         chk("a_start_expected", 64'(qa_sp.size() != 0), 1);
         if (qa_sp.size() != 0) last_sp_a = qa_sp.pop_front();
      end
      chk("a_startplace", 64'(ia.startplace), 64'(last_sp_a));
      chk("a_fin_only_on_change", 64'(ia.finalstart & ~ia.change), 0);
      if (ia.work) begin
         chk("a_fsum_held", 64'(ia.fsum), 64'(exp_fs_a));
         chk("a_f2sum_held", 64'(ia.f2sum), 64'(exp_f2_a));
      end
      if (ia.change) begin
         chk("a_change_expected", 64'(qa_fin.size() != 0), 1);
         if (qa_fin.size() != 0) chk("a_finalstart", 64'(ia.finalstart), 64'(qa_fin.pop_front()));
      end
      if (ia.done) begin
         done_cnt_a++;
         chk("a_done_expected", 64'(qa_done.size() != 0), 1);
         if (qa_done.size() != 0) chk("a_done_cycle", 64'(cyc), 64'(qa_done.pop_front()));
         chk("a_done_work", 64'(ia.work), 0);
         chk("a_done_busy", 64'(ia.busy), 1);
         chk("a_done_fsum", 64'(ia.fsum), 64'(exp_fs_a));
      end
   end

   // monitor for unit B
   always @(negedge clk) if (rst_n) begin
      logic [5:0] e;
      if (ib.valid) begin
         chk("b_valid_expected", 64'(qb_pix.size() != 0), 1);
         if (qb_pix.size() != 0) begin
            e = qb_pix.pop_front();
            chk("b_pixels", 64'({ib.fdata, ib.gdata}), 64'(e));
            last_pix_b = e;
         end
      end else begin
         chk("b_pix_hold", 64'({ib.fdata, ib.gdata}), 64'(last_pix_b));
      end
      if (ib.startsig) begin
         chk("b_start_expected", 64'(qb_sp.size() != 0), 1);
         if (qb_sp.size() != 0) last_sp_b = qb_sp.pop_front();
      end
      chk("b_startplace", 64'(ib.startplace), 64'(last_sp_b));
      chk("b_fin_only_on_change", 64'(ib.finalstart & ~ib.change), 0);
      if (ib.change) begin
         chk("b_change_expected", 64'(qb_fin.size() != 0), 1);
         if (qb_fin.size() != 0) chk("b_finalstart", 64'(ib.finalstart), 64'(qb_fin.pop_front()));
         chk("b_fsum", 64'(ib.fsum), 64'(exp_fs_b));
         chk("b_f2sum", 64'(ib.f2sum), 64'(exp_f2_b));
      end
      if (ib.done) begin
         done_cnt_b++;
         chk("b_done_expected", 64'(qb_done.size() != 0), 1);
         if (qb_done.size() != 0) chk("b_done_cycle", 64'(cyc), 64'(qb_done.pop_front()));
      end
   end

   task automatic flush_all();
      qa_pix.delete(); qa_sp.delete(); qa_fin.delete(); qa_done.delete();
      qb_pix.delete(); qb_sp.delete(); qb_fin.delete(); qb_done.delete();
      last_pix_a = '0; last_sp_a = '0; last_pix_b = '0; last_sp_b = '0;
   endtask

   // one go on unit A; rego_at re-pulses go, abort_at asserts reset (cycle offsets from go)
   task automatic run_a(input logic [7:0] base, input int fs, input int f2,
                        input int rego_at, input int abort_at);
      int g0;
      int dc0;
      dc0 = done_cnt_a;
      @(posedge clk); #2;
      ia.base_place = base;
      ia.go = 1'b1;
      g0 = cyc;
      exp_fs_a = 11'(fs);
      exp_f2_a = 14'(f2);
      for (int dd = 0; dd < 4; dd++) begin
         qa_sp.push_back(8'(base + 8'(dd)));
         qa_fin.push_back(dd == 3);
         for (int ii = 0; ii < 8; ii++)
            qa_pix.push_back({fmem_a[8'(base + 8'(ii))], gmem_a[8'(base + 8'(dd) + 8'(ii))]});
      end
      qa_done.push_back(g0 + 54);
      for (int k = 1; k <= 58; k++) begin
         @(posedge clk); #2;
         ia.go = (k == rego_at);
         if (k == 1)  chk("a_busy_after_go", 64'(ia.busy), 1);
         if (k == 55) chk("a_busy_after_done", 64'(ia.busy), 0);
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("a_abort_outputs_zero", outs_a(), 0);
            flush_all();
            repeat (2) @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (60) @(posedge clk);
            chk("a_no_done_after_abort", 64'(done_cnt_a - dc0), 0);
            return;
         end
      end
      chk("a_one_done", 64'(done_cnt_a - dc0), 1);
      chk("a_queues_drained", 64'(qa_pix.size() + qa_sp.size() + qa_fin.size() + qa_done.size()), 0);
      chk("a_fsum_final", 64'(ia.fsum), 64'(fs));
      chk("a_f2sum_final", 64'(ia.f2sum), 64'(f2));
   endtask

   initial begin
      ia.go = 1'b0; ia.base_place = '0;
      ib.go = 1'b0; ib.base_place = '0;
      for (int a = 0; a < 256; a++) begin
         fmem_a[a] = 3'd7;
         gmem_a[a] = 3'(a % 8);
         fmem_b[a] = 3'd0;
         gmem_b[a] = 3'd0;
      end
      exp_fs_a = '0; exp_f2_a = '0; exp_fs_b = '0; exp_f2_b = '0;
      repeat (3) @(posedge clk);
      #2;
      chk("a_reset_outputs_zero", outs_a(), 0);
      chk("b_reset_outputs_zero", outs_b(), 0);
      rst_n = 1'b1;

      // all-7 reference: 8*7=56, 8*49=392
      run_a(8'd0, 56, 392, 0, 0);

      // ramp reference 0..7: sum 28, sum of squares 140
      for (int a = 0; a < 256; a++) fmem_a[a] = 3'(a % 8);
      run_a(8'd0, 28, 140, 0, 0);

      // base 250 wraps; reference values 2..7,0,1 still sum to 28 / 140
      for (int a = 0; a < 256; a++) gmem_a[a] = 3'((a * 3) % 8);
      run_a(8'd250, 28, 140, 0, 0);

      // go during first candidate's stream must be ignored
      for (int a = 0; a < 256; a++) fmem_a[a] = 3'd7;
      run_a(8'd0, 56, 392, 15, 0);

      // reset during second candidate's stream, then a clean run
      run_a(8'd0, 56, 392, 0, 25);
      run_a(8'd0, 56, 392, 0, 0);

      // unit B: WIN=1, NCAND=1, done at cycle 7
      fmem_b[10] = 3'd5;
      gmem_b[10] = 3'd3;
      begin
         int g0;
         int dc0;
         dc0 = done_cnt_b;
         @(posedge clk); #2;
         ib.base_place = 8'd10;
         ib.go = 1'b1;
         g0 = cyc;
         exp_fs_b = 11'd5;
         exp_f2_b = 14'd25;
         qb_sp.push_back(8'd10);
         qb_fin.push_back(1'b1);
         qb_pix.push_back({3'd5, 3'd3});
         qb_done.push_back(g0 + 7);
         @(posedge clk); #2;
         ib.go = 1'b0;
         repeat (12) @(posedge clk);
         #2;
         chk("b_one_done", 64'(done_cnt_b - dc0), 1);
         chk("b_queues_drained", 64'(qb_pix.size() + qb_sp.size() + qb_fin.size() + qb_done.size()), 0);
         chk("b_idle_busy", 64'(ib.busy), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/disparity_window_feeder.md
Name: disparity_window_feeder

Overview:
- Sequencer/stream source that drives the correlation calc unit in the stereo disparity datapath.
- Reads one reference (left) window and a series of shifted candidate (right) windows from two synchronous row memories.
- Precomputes the reference window sums (fsum, f2sum).
- Emits per-candidate pixel pairs with the startsig/work/valid/change/finalstart framing that the calc unit consumes.

Parameters:
- WIN, 8, window length in pixels (1..256).
- NCAND, 16, number of candidate disparities scanned per go (1..256).

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- go  input  1  start pulse; sampled only in IDLE
- base_place  input  8  reference window start column; latched on accepted go
- f_addr  output  8  left-row memory read address
- f_rd  input  3  left-row read data, valid 1 cycle after f_addr
- g_addr  output  8  right-row memory read address
- g_rd  input  3  right-row read data, valid 1 cycle after g_addr
- startplace  output  8  base + current disparity (mod 256)
- startsig  output  1  1-cycle pulse at the start of each candidate
- work  output  1  high from the first START to the last CHANGE inclusive
- valid  output  1  fdata/gdata qualify this cycle
- fdata  output  3  reference pixel
- gdata  output  3  candidate pixel
- change  output  1  1-cycle pulse after the last sample of a candidate
- finalstart  output  1  coincident with change on the last candidate only
- fsum  output  11  sum of the reference window pixels; held stable while work=1
- f2sum  output  14  sum of squared reference window pixels; held stable while work=1
- busy  output  1  high from the cycle after go until done
- done  output  1  1-cycle completion pulse

Behaviour:
- Reset: all outputs 0, FSM in IDLE, disparity counter d=0, sums cleared. Reset mid-operation aborts immediately; no done pulse is generated.
- FSM states: IDLE, PRE, START, STREAM, CHANGE, DONE.
- IDLE:
  - go=1 latches base_place into B, sets d=0, clears fsum/f2sum; next state PRE.
  - go in any other state is ignored.
- PRE (WIN+1 cycles):
  - Cycles 0..WIN-1 drive f_addr = B+i (mod 256).
  - Each returned f_rd is accumulated one cycle later: fsum += f, f2sum += f*f (f*f zero-extended, unsigned).
  - No overflow is possible: 7*256 < 2048 and 49*256 < 16384.
  - After the final accumulate, go to START. valid=0 throughout PRE.
- START (1 cycle): startsig=1, startplace = B+d, work=1, internal index i=0.
- STREAM (WIN+1 cycles):
  - Issue cycles 0..WIN-1: f_addr = B+i, g_addr = B+d+i (both mod 256).
  - Data cycles 1..WIN: valid=1, fdata=f_rd, gdata=g_rd (registered; pixels aligned pairwise).
- CHANGE (1 cycle):
  - change=1; finalstart=1 iff d == NCAND-1.
  - If last candidate, go to DONE; else d++ and go to START.
- DONE (1 cycle): done=1, work=0, busy goes 0 next cycle, return to IDLE.
  - A go sampled in the cycle after DONE (IDLE) is accepted.
- Output holds:
  - startplace holds its value between START pulses.
  - fsum/f2sum hold until the next accepted go.
  - fdata/gdata hold their last value when valid=0.
- Latency: with go sampled at cycle 0, done is high at cycle 1 + (WIN+1) + NCAND*(WIN+3).
- Edge cases:
  - WIN=1: STREAM is 2 cycles, with a single valid sample.
  - NCAND=1: finalstart coincides with the first change.
  - Address wrap-around at 255->0 is silent.

Test Plan:
- WIN=8, NCAND=4, base=0, f memory all 7 -> after PRE: fsum=56, f2sum=392; exactly 4 startsig, 32 valid cycles, 4 change; finalstart only on the 4th change; done at cycle 54.
- f[i]=i (0..7), g[i]=i, base=0 -> fsum=28, f2sum=140; candidate d=2 emits gdata sequence 2..7,0(g[8]),... from memory contents; startplace sequence 0,1,2,3.
- base=250, WIN=8, NCAND=4 -> f_addr wraps 250..255,0,1; last candidate g_addr 253..255,0..4; startplace 250..253.
- go pulsed again during STREAM -> ignored; no restart; done at same cycle as an undisturbed run; fsum unchanged.
- rst_n low during second candidate's STREAM -> all outputs 0 asynchronously, no done pulse; fresh go after release gives a normal run.
- NCAND=1, WIN=1 -> startsig, 1 valid, change+finalstart together; done at cycle 1+2+4=7.
